al_bcd_time_counter: RTL and testbench

AL_BCD_TIME_COUNTER -- requirements
Module: al_bcd_time_counter

---
 rtl/al_bcd_time_counter.sv | 180 ++++++++++++++++++
 tb/tb_al_bcd_time_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/al_bcd_time_counter.sv
// al_bcd_time_counter
//   BCD time-of-day counter with load validation, fast-set strobes and a
//   midnight rollover pulse. Supports 24h or 12h (AM/PM) display, with or
//   without a seconds field.
//
// Parameters
//   SHOW_SECONDS : 1 adds a BCD seconds field; tick is then a 1 s strobe,
//                  otherwise a 1 min strobe.
//   MODE_12H     : 1 selects 12h display with pm flag, 0 selects 24h.
//
// Ports
//   clk256           in   system clock, all state on rising edge
//   reset            in   synchronous active-high reset
//   tick             in   one-cycle advance strobe
//   time_in          in   BCD {hh,mm[,ss]} to load
//   pm_in            in   PM flag loaded with time_in (12h only)
//   load_new_time    in   one-cycle load strobe
//   inc_hour         in   fast-set hour strobe
//   inc_min          in   fast-set minute strobe
//   current_time_out out  registered BCD time
//   pm               out  registered PM flag (0 in 24h mode)
//   day_rollover     out  one-cycle pulse on midnight crossing
//   load_error       out  one-cycle pulse when a load is rejected
module al_bcd_time_counter #(
  parameter int unsigned SHOW_SECONDS = 0,
  parameter int unsigned MODE_12H     = 0,
  localparam int unsigned W           = (SHOW_SECONDS != 0) ? 24 : 16
) (
  input  logic         clk256,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] time_in,
  input  logic         pm_in,
  input  logic         load_new_time,
  input  logic         inc_hour,
  input  logic         inc_min,
  output logic [W-1:0] current_time_out,
  output logic         pm,
  output logic         day_rollover,
  output logic         load_error
);

  localparam logic [7:0] HourRst = (MODE_12H != 0) ? 8'h12 : 8'h00;

  logic [7:0] hh_q, hh_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic       pm_q, pm_d;
  logic       roll_q, roll_d;
  logic       err_q, err_d;

  // Two-digit BCD increment without wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Minutes/seconds increment, 59 wraps to 00.
  function automatic logic [7:0] inc_wrap60(input logic [7:0] v);
    if (v == 8'h59) return 8'h00;
    else            return bcd_inc(v);
  endfunction

  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Load field extraction; without seconds the seconds field loads as 00.
  logic [7:0] ld_hh, ld_mm, ld_ss;
  logic       load_ok;

  assign ld_hh = time_in[W-1 -: 8];
  assign ld_mm = time_in[W-9 -: 8];
  assign ld_ss = (SHOW_SECONDS != 0) ? time_in[7:0] : 8'h00;

  always_comb begin
    load_ok = digits_ok(ld_hh) && digits_ok(ld_mm) && digits_ok(ld_ss) &&
              (ld_mm[7:4] <= 4'd5) && (ld_ss[7:4] <= 4'd5);
    // Digits already checked, so raw compares follow BCD ordering.
    if (MODE_12H != 0) load_ok = load_ok && (ld_hh >= 8'h01) && (ld_hh <= 8'h12);
    else               load_ok = load_ok && (ld_hh <= 8'h23);
  end

  // Shared hour advance used by both tick carry and inc_hour.
  logic [7:0] hh_adv;
  logic       hh_to_noon;  // 11 -> 12 transition in 12h mode
  logic       hh_wrap24;   // 23 -> 00 transition in 24h mode

  always_comb begin
    hh_adv     = bcd_inc(hh_q);
    hh_to_noon = 1'b0;
    hh_wrap24  = 1'b0;
    if (MODE_12H != 0) begin
      if (hh_q == 8'h12) begin
        hh_adv = 8'h01;
      end else if (hh_q == 8'h11) begin
        hh_to_noon = 1'b1;
      end
    end else if (hh_q == 8'h23) begin
      hh_adv    = 8'h00;
      hh_wrap24 = 1'b1;
    end
  end

  logic sec_carry;

  always_comb begin
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    pm_d      = pm_q;
    roll_d    = 1'b0;
    err_d     = 1'b0;
    sec_carry = (SHOW_SECONDS == 0) || (ss_q == 8'h59);

    if (load_new_time) begin
      if (load_ok) begin
        hh_d = ld_hh;
        mm_d = ld_mm;
        ss_d = ld_ss;
        pm_d = (MODE_12H != 0) ? pm_in : 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (inc_hour || inc_min) begin
      // Fast-set fields move independently; no carries, no rollover.
      if (inc_hour) begin
        hh_d = hh_adv;
        if (hh_to_noon) pm_d = ~pm_q;
      end
      if (inc_min) begin
        mm_d = inc_wrap60(mm_q);
        ss_d = 8'h00;
      end
    end else if (tick) begin
      if (SHOW_SECONDS != 0) ss_d = inc_wrap60(ss_q);
      if (sec_carry) begin
        mm_d = inc_wrap60(mm_q);
        if (mm_q == 8'h59) begin
          hh_d = hh_adv;
          if (hh_to_noon) begin
            pm_d   = ~pm_q;
            // Only the PM -> AM toggle is midnight.
            roll_d = pm_q;
          end
          if (hh_wrap24) roll_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk256) begin
    if (reset) begin
      hh_q   <= HourRst;
      mm_q   <= 8'h00;
      ss_q   <= 8'h00;
      pm_q   <= 1'b0;
      roll_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
      pm_q   <= pm_d;
      roll_q <= roll_d;
      err_q  <= err_d;
    end
  end

  if (SHOW_SECONDS != 0) begin : g_sec
    assign current_time_out = {hh_q, mm_q, ss_q};
  end else begin : g_nosec
    assign current_time_out = {hh_q, mm_q};
  end

  assign pm           = (MODE_12H != 0) ? pm_q : 1'b0;
  assign day_rollover = roll_q;
  assign load_error   = err_q;

endmodule

// File: tb/tb_al_bcd_time_counter.sv
// Bench for al_bcd_time_counter: one 24h/no-seconds instance (a) and one
// 12h/with-seconds instance (b). Directed vector table, then a random tick
// run compared against an elapsed-time model.
module tb_al_bcd_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tick_a, ld_a, ih_a, im_a, pin_a;
  logic [15:0] tin_a, out_a;
  logic        pm_a, roll_a, err_a;
  logic        tick_b, ld_b, ih_b, im_b, pin_b;
  logic [23:0] tin_b, out_b;
  logic        pm_b, roll_b, err_b;

  al_bcd_time_counter u_dut_a (
    .clk256          (clk),
    .reset           (rst),
    .tick            (tick_a),
    .time_in         (tin_a),
    .pm_in           (pin_a),
    .load_new_time   (ld_a),
    .inc_hour        (ih_a),
    .inc_min         (im_a),
    .current_time_out(out_a),
    .pm              (pm_a),
    .day_rollover    (roll_a),
    .load_error      (err_a)
  );

  al_bcd_time_counter #(
    .SHOW_SECONDS(1),
    .MODE_12H    (1)
  ) u_dut_b (
    .clk256          (clk),
    .reset           (rst),
    .tick            (tick_b),
    .time_in         (tin_b),
    .pm_in           (pin_b),
    .load_new_time   (ld_b),
    .inc_hour        (ih_b),
    .inc_min         (im_b),
    .current_time_out(out_b),
    .pm              (pm_b),
    .day_rollover    (roll_b),
    .load_error      (err_b)
  );

  typedef struct {
    string       name;
    logic        sel;   // 0: dut a, 1: dut b
    logic        rst;
    logic        ld;
    logic [23:0] tin;
    logic        pin;
    logic        ih;
    logic        im;
    logic        tk;
    logic [23:0] et;
    logic        ep;
    logic        er;
    logic        ee;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic sel, input logic r, input logic ld,
                     input logic [23:0] tin, input logic pin, input logic ih, input logic im,
                     input logic tk, input logic [23:0] et, input logic ep, input logic er,
                     input logic ee);
    vec_t v;
    v.name = name; v.sel = sel; v.rst = r; v.ld = ld; v.tin = tin; v.pin = pin;
    v.ih = ih; v.im = im; v.tk = tk; v.et = et; v.ep = ep; v.er = er; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    tick_a = 1'b0; ld_a = 1'b0; ih_a = 1'b0; im_a = 1'b0; pin_a = 1'b0; tin_a = '0;
    tick_b = 1'b0; ld_b = 1'b0; ih_b = 1'b0; im_b = 1'b0; pin_b = 1'b0; tin_b = '0;
  endtask

  task automatic apply(input vec_t v);
    idle_inputs();
    rst = v.rst;
    if (!v.sel) begin
      ld_a = v.ld; tin_a = v.tin[15:0]; pin_a = v.pin; ih_a = v.ih; im_a = v.im; tick_a = v.tk;
    end else begin
      ld_b = v.ld; tin_b = v.tin; pin_b = v.pin; ih_b = v.ih; im_b = v.im; tick_b = v.tk;
    end
    @(posedge clk);
    #1;
    if (!v.sel) begin
      check({v.name, ".time"}, {16'h0, out_a}, {16'h0, v.et[15:0]});
      check({v.name, ".pm"}, {31'h0, pm_a}, {31'h0, v.ep});
      check({v.name, ".roll"}, {31'h0, roll_a}, {31'h0, v.er});
      check({v.name, ".err"}, {31'h0, err_a}, {31'h0, v.ee});
    end else begin
      check({v.name, ".time"}, {8'h0, out_b}, {8'h0, v.et});
      check({v.name, ".pm"}, {31'h0, pm_b}, {31'h0, v.ep});
      check({v.name, ".roll"}, {31'h0, roll_b}, {31'h0, v.er});
      check({v.name, ".err"}, {31'h0, err_b}, {31'h0, v.ee});
    end
  endtask

  function automatic logic [7:0] bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Every nibble a decimal digit; minute/second tens at most 5.
  function automatic logic legal(input logic [23:0] t, input logic secs, input logic h12);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    if (secs) begin
      if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
      if (h12 && (t[23:16] < 8'h01 || t[23:16] > 8'h12)) ok = 1'b0;
    end else begin
      if (t[7:4] > 4'd5 || t[15:8] > 8'h23) ok = 1'b0;
    end
    return ok;
  endfunction

  int          min_a, sec_b, h24, h12;
  logic        eroll_a, eroll_b;
  logic [23:0] exp_b;

  initial begin
    idle_inputs();
    rst = 1'b1;

    //   name        sel rst ld tin        pin ih im tk  exp_time   pm roll err
    add("a_reset",    0, 1, 0, 24'h0,      0, 0, 0, 0, 24'h0000,  0, 0, 0);
    add("a_ld2359",   0, 0, 1, 24'h2359,   0, 0, 0, 0, 24'h2359,  0, 0, 0);
    add("a_midnight", 0, 0, 0, 24'h0,      0, 0, 0, 1, 24'h0000,  0, 1, 0);
    add("a_rollend",  0, 0, 0, 24'h0,      0, 0, 0, 0, 24'h0000,  0, 0, 0);
    add("a_tick1",    0, 0, 0, 24'h0,      0, 0, 0, 1, 24'h0001,  0, 0, 0);
    add("a_ld0959",   0, 0, 1, 24'h0959,   0, 0, 0, 0, 24'h0959,  0, 0, 0);
    add("a_hcarry",   0, 0, 0, 24'h0,      0, 0, 0, 1, 24'h1000,  0, 0, 0);
    add("a_bad2460",  0, 0, 1, 24'h2460,   0, 0, 0, 0, 24'h1000,  0, 0, 1);
    add("a_errend",   0, 0, 0, 24'h0,      0, 0, 0, 0, 24'h1000,  0, 0, 0);
    add("a_bad1a00",  0, 0, 1, 24'h1a00,   0, 0, 0, 0, 24'h1000,  0, 0, 1);
    add("a_ld2359b",  0, 0, 1, 24'h2359,   0, 0, 0, 0, 24'h2359,  0, 0, 0);
    add("a_incboth",  0, 0, 0, 24'h0,      0, 1, 1, 1, 24'h0000,  0, 0, 0);
    add("a_incafter", 0, 0, 0, 24'h0,      0, 0, 0, 0, 24'h0000,  0, 0, 0);
    add("a_ld1259",   0, 0, 1, 24'h1259,   0, 0, 0, 0, 24'h1259,  0, 0, 0);
    add("a_incmin",   0, 0, 0, 24'h0,      0, 0, 1, 0, 24'h1200,  0, 0, 0);
    add("a_ld2330",   0, 0, 1, 24'h2330,   0, 0, 0, 0, 24'h2330,  0, 0, 0);
    add("a_inchr23",  0, 0, 0, 24'h0,      0, 1, 0, 0, 24'h0030,  0, 0, 0);
    add("a_ldtick",   0, 0, 1, 24'h1111,   0, 0, 1, 1, 24'h1111,  0, 0, 0);
    add("a_rstld",    0, 1, 1, 24'h1234,   0, 0, 0, 0, 24'h0000,  0, 0, 0);
    add("a_tickrst",  0, 0, 0, 24'h0,      0, 0, 0, 1, 24'h0001,  0, 0, 0);

    add("b_reset",    1, 1, 0, 24'h0,      0, 0, 0, 0, 24'h120000, 0, 0, 0);
    add("b_ld1159",   1, 0, 1, 24'h115959, 0, 0, 0, 0, 24'h115959, 0, 0, 0);
    add("b_noon",     1, 0, 0, 24'h0,      0, 0, 0, 1, 24'h120000, 1, 0, 0);
    add("b_ld1259",   1, 0, 1, 24'h125959, 1, 0, 0, 0, 24'h125959, 1, 0, 0);
    add("b_one",      1, 0, 0, 24'h0,      0, 0, 0, 1, 24'h010000, 1, 0, 0);
    add("b_ld1159pm", 1, 0, 1, 24'h115959, 1, 0, 0, 0, 24'h115959, 1, 0, 0);
    add("b_midnight", 1, 0, 0, 24'h0,      0, 0, 0, 1, 24'h120000, 0, 1, 0);
    add("b_rollend",  1, 0, 0, 24'h0,      0, 0, 0, 0, 24'h120000, 0, 0, 0);
    add("b_bad0000",  1, 0, 1, 24'h000000, 1, 0, 0, 0, 24'h120000, 0, 0, 1);
    add("b_bad1300",  1, 0, 1, 24'h130000, 0, 0, 0, 0, 24'h120000, 0, 0, 1);
    add("b_ld1100",   1, 0, 1, 24'h110000, 0, 0, 0, 0, 24'h110000, 0, 0, 0);
    add("b_inchr11",  1, 0, 0, 24'h0,      0, 1, 0, 0, 24'h120000, 1, 0, 0);
    add("b_inchr12",  1, 0, 0, 24'h0,      0, 1, 0, 0, 24'h010000, 1, 0, 0);
    add("b_ld0130",   1, 0, 1, 24'h013030, 0, 0, 0, 0, 24'h013030, 0, 0, 0);
    add("b_incmin",   1, 0, 0, 24'h0,      0, 0, 1, 0, 24'h013100, 0, 0, 0);
    add("b_ld1259s",  1, 0, 1, 24'h125945, 0, 0, 0, 0, 24'h125945, 0, 0, 0);
    add("b_incboth",  1, 0, 0, 24'h0,      0, 1, 1, 1, 24'h010000, 0, 0, 0);
    add("b_badss60",  1, 0, 1, 24'h015960, 0, 0, 0, 0, 24'h010000, 0, 0, 1);
    add("b_rstld",    1, 1, 1, 24'h123456, 1, 0, 0, 0, 24'h120000, 0, 0, 0);
    add("b_tickrst",  1, 0, 0, 24'h0,      0, 0, 0, 1, 24'h120001, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Random tick run across midnight on both instances.
    idle_inputs();
    ld_a = 1'b1; tin_a = 16'h2300;
    ld_b = 1'b1; tin_b = 24'h115000; pin_b = 1'b1;
    @(posedge clk);
    #1;
    check("r_ld_a", {16'h0, out_a}, 32'h2300);
    check("r_ld_b", {8'h0, out_b}, 32'h115000);
    min_a = 23 * 60;
    sec_b = 23 * 3600 + 50 * 60;
    for (int c = 0; c < 2000; c++) begin
      idle_inputs();
      tick_a = 1'($urandom_range(0, 1));
      tick_b = 1'($urandom_range(0, 1));
      eroll_a = 1'b0;
      eroll_b = 1'b0;
      if (tick_a) begin
        min_a = (min_a + 1) % 1440;
        eroll_a = (min_a == 0);
      end
      if (tick_b) begin
        sec_b = (sec_b + 1) % 86400;
        eroll_b = (sec_b == 0);
      end
      h24   = sec_b / 3600;
      h12   = (h24 % 12 == 0) ? 12 : h24 % 12;
      exp_b = {bcd2(h12), bcd2((sec_b / 60) % 60), bcd2(sec_b % 60)};
      @(posedge clk);
      #1;
      check("r_time_a", {16'h0, out_a}, {16'h0, bcd2(min_a / 60), bcd2(min_a % 60)});
      check("r_roll_a", {31'h0, roll_a}, {31'h0, eroll_a});
      check("r_legal_a", {31'h0, legal({8'h0, out_a}, 1'b0, 1'b0)}, 32'h1);
      check("r_time_b", {8'h0, out_b}, {8'h0, exp_b});
      check("r_pm_b", {31'h0, pm_b}, {31'h0, (h24 >= 12)});
      check("r_roll_b", {31'h0, roll_b}, {31'h0, eroll_b});
      check("r_legal_b", {31'h0, legal(out_b, 1'b1, 1'b1)}, 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
